// File: rtl/mem_pkg.sv
// Shared definitions for the word-copy engine: default widths, RAM depth and FSM encoding.
package mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MEM_DEPTH  = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Single-port RAM bus between the copy engine (master) and the RAM (slave).
interface mem_copy_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    // ram_cs=1/ram_we=0: read, ram_rdata valid combinationally in the same cycle.
    // ram_cs=1/ram_we=1: ram_wdata written to ram_addr at the rising edge. ram_we implies ram_cs.
    logic              ram_cs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_cs,
        output ram_we,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_cs,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/mem_copy_engine.sv
// Copies a block of RAM words from a source to a destination address, one word every
// two cycles (read then write), with wrapping pointers, length checking and abort.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count,
    output state_t            state,
    mem_copy_engine_if.master ram
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] LEN_ZERO = '0;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ram.ram_cs    = 1'b0;
        ram.ram_we    = 1'b0;
        ram.ram_addr  = '0;
        ram.ram_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length == LEN_ZERO || length > LEN_MAX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                ram.ram_cs   = 1'b1;
                ram.ram_addr = src_ptr;
                state_d      = abort ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                ram.ram_cs    = 1'b1;
                ram.ram_we    = 1'b1;
                ram.ram_addr  = dst_ptr;
                ram.ram_wdata = hold_q;
                // An abort still lets the write at this edge land and be counted.
                state_d = (abort || remaining == LEN_ONE) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= length;
                        count_q   <= '0;
                        err_q     <= (length > LEN_MAX);
                    end
                end
                ST_READ: begin
                    hold_q <= ram.ram_rdata;
                end
                ST_WRITE: begin
                    // Pointers are ADDR_W bits wide, so the increment wraps at the RAM depth.
                    src_ptr   <= src_ptr + ADDR_W'(1);
                    dst_ptr   <= dst_ptr + ADDR_W'(1);
                    remaining <= remaining - LEN_ONE;
                    count_q   <= count_q + LEN_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign done  = (state_q == ST_DONE);
    assign err   = err_q;
    assign count = count_q;
    assign state = state_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: RAM model, randomized commands and a word-level copy model.
module tb_mem_copy_engine;
  import mem_pkg::*;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [4:0]   src_addr;
  logic [4:0]   dst_addr;
  logic [5:0]   length;
  logic         abort;
  logic         busy;
  logic         done;
  logic         err;
  logic [5:0]   count;
  state_t       state;

  mem_copy_engine_if #(.DATA_W(32), .ADDR_W(5)) ram_bus ();

  mem_copy_engine #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .count    (count),
    .state    (state),
    .ram      (ram_bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM model with a preload port for the bench
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        tb_wr;
  logic [4:0]  tb_waddr;
  logic [31:0] tb_wdata;

  assign ram_bus.ram_rdata = mem[ram_bus.ram_addr];

  always @(posedge clock) begin
    if (tb_wr) mem[tb_waddr] <= tb_wdata;
    else if (ram_bus.ram_cs && ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
  end

  // scoreboard
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus monitor: every access in order against the expected queue; idle bus must be all zero
  always @(negedge clock) begin
    if (reset_n) begin
      if (ram_bus.ram_cs) begin
        if (exp_q.size() == 0) check("unexpected_access", {ram_bus.ram_we, ram_bus.ram_addr}, 6'h3f);
        else check("access_we_addr", {ram_bus.ram_we, ram_bus.ram_addr}, exp_q.pop_front());
      end else begin
        check("idle_bus", {ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_wdata}, 64'd0);
      end
    end
  end

  // driver tasks
  task automatic poke_mem(input logic [4:0] a, input logic [31:0] v);
    @(negedge clock);
    tb_wr = 1'b1; tb_waddr = a; tb_wdata = v;
    @(negedge clock);
    tb_wr = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s_mem%0d", tag, i), mem[i], ref_mem[i]);
  endtask

  function automatic int n_writes(input int len, input int abort_wr);
    if (len == 0 || len > 32) return 0;
    if (abort_wr > 0 && abort_wr < len) return abort_wr;
    return len;
  endfunction

  // reference model: word-by-word forward copy, modulo-32 addresses
  task automatic model_copy(input int s, input int d, input int nw);
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back({1'b0, 5'((s + i) % 32)});
      exp_q.push_back({1'b1, 5'((d + i) % 32)});
      ref_mem[(d + i) % 32] = ref_mem[(s + i) % 32];
    end
  endtask

  task automatic do_cmd(input logic [4:0] s, input logic [4:0] d, input logic [5:0] len,
                        input int abort_wr, input bit poke, input bit abort_with_start);
    int nw, busy_cnt, done_cnt, done_at, wr_idx, cyc;
    bit fin;
    nw = n_writes(int'(len), abort_wr);
    model_copy(int'(s), int'(d), nw);
    @(negedge clock);
    start = 1'b1; src_addr = s; dst_addr = d; length = len; abort = abort_with_start;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    src_addr = 5'($urandom); dst_addr = 5'($urandom); length = 6'($urandom);
    busy_cnt = 0; done_cnt = 0; done_at = -1; wr_idx = 0; fin = 1'b0;
    for (cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (ram_bus.ram_we) wr_idx++;
      abort = (abort_wr > 0) && ram_bus.ram_we && (wr_idx == abort_wr);
      start = poke && busy && ($urandom_range(0, 2) == 0);
      if (done_at >= 0 && cyc >= done_at + 1) fin = 1'b1;
      if (!fin) @(negedge clock);
    end
    start = 1'b0; abort = 1'b0;
    check("cmd_finished", fin, 1'b1);
    check("busy_cycles", busy_cnt, 2 * nw);
    check("done_pulses", done_cnt, 1);
    check("done_latency", done_at, 2 * nw);
    check("count", count, nw);
    check("err", err, len > 6'd32);
    check("state_idle", state, ST_IDLE);
    check("access_q_empty", exp_q.size(), 0);
    exp_q.delete();
    check_mem("cmd");
  endtask

  initial begin
    int s, d, len, ab;
    logic [31:0] x;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    tb_wr = 1'b0; tb_waddr = '0; tb_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst_state", state, ST_IDLE);
    check("rst_outputs", {busy, done, err, count}, 64'd0);
    check("rst_bus", {ram_bus.ram_cs, ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_wdata}, 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) poke_mem(5'(i), $urandom);

    // basic copy, wrap, length edge cases
    do_cmd(5'd0, 5'd8, 6'd4, 0, 1'b0, 1'b0);
    do_cmd(5'd30, 5'd2, 6'd4, 0, 1'b0, 1'b0);
    do_cmd(5'd7, 5'd9, 6'd0, 0, 1'b0, 1'b0);
    do_cmd(5'd7, 5'd9, 6'd33, 0, 1'b0, 1'b0);
    check("err_holds_idle", err, 1'b1);
    do_cmd(5'd3, 5'd3, 6'd32, 0, 1'b0, 1'b0);
    // abort during the 3rd write of a 10-word copy
    do_cmd(5'd4, 5'd20, 6'd10, 3, 1'b0, 1'b0);
    // overlap with forward semantics, start pokes while busy
    x = $urandom;
    poke_mem(5'd0, x);
    do_cmd(5'd0, 5'd1, 6'd3, 0, 1'b1, 1'b0);
    check("overlap_word3", mem[3], x);
    // abort together with start in IDLE is ignored
    do_cmd(5'd5, 5'd25, 6'd6, 0, 1'b0, 1'b1);

    // reset during the 2nd write of a 5-word copy
    model_copy(12, 20, 1);
    exp_q.push_back({1'b0, 5'd13});
    exp_q.push_back({1'b1, 5'd21});
    @(negedge clock);
    start = 1'b1; src_addr = 5'd12; dst_addr = 5'd20; length = 6'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_mid_we_before", ram_bus.ram_we, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_bus", {ram_bus.ram_cs, ram_bus.ram_we}, 2'b00);
    check("rst_mid_outputs", {busy, done, err, count}, 64'd0);
    @(negedge clock);
    check("rst_mid_no_done", done, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_after_done", done, 1'b0);
    check("rst_after_state", state, ST_IDLE);
    check("rst_access_q", exp_q.size(), 0);
    exp_q.delete();
    check_mem("rst");
    do_cmd(5'd12, 5'd20, 6'd5, 0, 1'b0, 1'b0);

    // randomized commands
    for (int k = 0; k < 20; k++) begin
      s = $urandom_range(0, 31);
      d = $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0: len = 0;
        1: len = $urandom_range(33, 63);
        default: len = $urandom_range(1, 32);
      endcase
      ab = (len >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
      do_cmd(5'(s), 5'(d), 6'(len), ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
